// File: rtl/acc_alu_pkg.sv
// ============================================================================
// Module  : acc_alu_pkg
// Brief   : Shared opcode encodings and width constants for the accumulator ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_alu_pkg;

  localparam int c_DATA_W = 8;
  localparam int c_OP_W   = 9;

  typedef enum logic [c_OP_W-1:0] {
    OP_ADD = 9'h000,
    OP_ADC = 9'h001,
    OP_SUB = 9'h002,
    OP_SBC = 9'h003,
    OP_AND = 9'h004,
    OP_OR  = 9'h005,
    OP_XOR = 9'h006,
    OP_NOT = 9'h007,
    OP_SHL = 9'h008,
    OP_SHR = 9'h009,
    OP_ROL = 9'h00A,
    OP_ROR = 9'h00B,
    OP_INC = 9'h00C,
    OP_DEC = 9'h00D,
    OP_MOV = 9'h00E,
    OP_CMP = 9'h00F,
    OP_MUL = 9'h010
  } op_t;

  localparam op_t c_OP_MUL = OP_MUL;

endpackage

`default_nettype wire

// File: rtl/acc_alu_core.sv
// ============================================================================
// Module  : acc_alu_core
// Brief   : Combinational ALU datapath: result, carry/borrow, zero, negative.
//           Multiply (op 0x010) is present only when ACC_ALU_MUL_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_alu_core
  import acc_alu_pkg::*;
(
  input  logic [c_DATA_W-1:0] in_a,
  input  logic [c_DATA_W-1:0] in_acc,
  input  logic                ci,
  input  logic [c_OP_W-1:0]   op,
  output logic [c_DATA_W-1:0] res,
  output logic                co,
  output logic                z,
  output logic                neg
);

  logic [c_DATA_W:0]   w_t9;
  logic [c_DATA_W-1:0] w_flag_val;
`ifdef ACC_ALU_MUL_EN
  logic [2*c_DATA_W-1:0] w_prod;
`endif

  always_comb begin
    w_t9  = '0;
    res   = in_acc;
    co    = 1'b0;
`ifdef ACC_ALU_MUL_EN
    w_prod = '0;
`endif
    case (op)
      OP_ADD: begin w_t9 = {1'b0, in_acc} + {1'b0, in_a};                 res = w_t9[7:0]; co = w_t9[8]; end
      OP_ADC: begin w_t9 = {1'b0, in_acc} + {1'b0, in_a} + {8'b0, ci};    res = w_t9[7:0]; co = w_t9[8]; end
      // Bit 8 of the 9-bit difference is the borrow out.
      OP_SUB: begin w_t9 = {1'b0, in_acc} - {1'b0, in_a};                 res = w_t9[7:0]; co = w_t9[8]; end
      OP_SBC: begin w_t9 = {1'b0, in_acc} - {1'b0, in_a} - {8'b0, ci};    res = w_t9[7:0]; co = w_t9[8]; end
      OP_AND: res = in_acc & in_a;
      OP_OR:  res = in_acc | in_a;
      OP_XOR: res = in_acc ^ in_a;
      OP_NOT: res = ~in_acc;
      OP_SHL: begin res = {in_acc[6:0], 1'b0}; co = in_acc[7]; end
      OP_SHR: begin res = {1'b0, in_acc[7:1]}; co = in_acc[0]; end
      OP_ROL: begin res = {in_acc[6:0], ci};   co = in_acc[7]; end
      OP_ROR: begin res = {ci, in_acc[7:1]};   co = in_acc[0]; end
      OP_INC: begin w_t9 = {1'b0, in_acc} + 9'd1; res = w_t9[7:0]; co = w_t9[8]; end
      OP_DEC: begin w_t9 = {1'b0, in_acc} - 9'd1; res = w_t9[7:0]; co = w_t9[8]; end
      OP_MOV: res = in_a;
      // CMP leaves the accumulator intact; flags come from the difference.
      OP_CMP: begin w_t9 = {1'b0, in_acc} - {1'b0, in_a}; res = in_acc; co = w_t9[8]; end
`ifdef ACC_ALU_MUL_EN
      c_OP_MUL: begin
        w_prod = {8'b0, in_acc} * {8'b0, in_a};
        res    = w_prod[7:0];
        co     = |w_prod[15:8];
      end
`endif
      default: begin res = in_acc; co = 1'b0; end
    endcase
  end

  assign w_flag_val = (op == OP_CMP) ? w_t9[7:0] : res;
  assign z          = (w_flag_val == '0);
  assign neg        = w_flag_val[c_DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/acc_alu.sv
// ============================================================================
// Module  : acc_alu
// Brief   : 8-bit accumulator ALU with registered result and flags, latency 1.
//           Define ACC_ALU_MUL_EN to enable the MUL opcode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_alu
  import acc_alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [c_DATA_W-1:0] in_a,
  input  logic [c_DATA_W-1:0] in_acc,
  input  logic                ci,
  input  logic [c_OP_W-1:0]   op,
  output logic [c_DATA_W-1:0] acc,
  output logic                co,
  output logic                z,
  output logic                neg
);

  logic [c_DATA_W-1:0] w_res;
  logic                w_co;
  logic                w_z;
  logic                w_neg;

  logic [c_DATA_W-1:0] r_acc;
  logic                r_co;
  logic                r_z;
  logic                r_neg;

  acc_alu_core u_core (
    .in_a   (in_a),
    .in_acc (in_acc),
    .ci     (ci),
    .op     (op),
    .res    (w_res),
    .co     (w_co),
    .z      (w_z),
    .neg    (w_neg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_co  <= 1'b0;
      r_z   <= 1'b1;
      r_neg <= 1'b0;
    end else begin
      r_acc <= w_res;
      r_co  <= w_co;
      r_z   <= w_z;
      r_neg <= w_neg;
    end
  end

  assign acc = r_acc;
  assign co  = r_co;
  assign z   = r_z;
  assign neg = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_acc_alu.sv
// ============================================================================
// Module  : tb_acc_alu
// Brief   : Directed self-checking bench for acc_alu (honours ACC_ALU_MUL_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_alu;
  import acc_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_a;
  logic [7:0] in_acc;
  logic       ci;
  logic [8:0] op;
  logic [7:0] acc;
  logic       co;
  logic       z;
  logic       neg;

  int n_pass  = 0;
  int n_total = 0;

  acc_alu dut (
    .clk    (clk),
    .reset  (reset),
    .in_a   (in_a),
    .in_acc (in_acc),
    .ci     (ci),
    .op     (op),
    .acc    (acc),
    .co     (co),
    .z      (z),
    .neg    (neg)
  );

  always #5 clk = ~clk;

  // Drive one op, clock it in, and return sampled 1 time unit after the edge.
  task automatic drive(input logic [8:0] o, input logic [7:0] x, input logic [7:0] a,
                       input logic c, input logic rst);
    op = o; in_acc = x; in_a = a; ci = c; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    drive(OP_ADD, 8'h00, 8'h00, 1'b0, 1'b1);
    n_total++;
    if ({acc, co, z, neg} !== {8'h00, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_hold: got acc=%02h co=%b z=%b neg=%b want 00 0 1 0", acc, co, z, neg);
    else n_pass++;
    drive(OP_MOV, 8'h00, 8'h85, 1'b0, 1'b0);
    drive(OP_ADD, 8'h33, 8'h44, 1'b1, 1'b1);
    n_total++;
    if ({acc, co, z, neg} !== {8'h00, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_over_add: got acc=%02h co=%b z=%b neg=%b want 00 0 1 0", acc, co, z, neg);
    else n_pass++;
  endtask

  // Vector table: op, in_acc, in_a, ci, expected {acc,co,z,neg}
  task automatic test_ops();
    logic [8:0]  t_op  [16];
    logic [7:0]  t_x   [16];
    logic [7:0]  t_a   [16];
    logic        t_c   [16];
    logic [10:0] t_exp [16];
    t_op[0]  = OP_ADD; t_x[0]  = 8'h18; t_a[0]  = 8'h10; t_c[0]  = 1'b0; t_exp[0]  = {8'h28, 3'b000};
    t_op[1]  = OP_ADC; t_x[1]  = 8'hFF; t_a[1]  = 8'h01; t_c[1]  = 1'b1; t_exp[1]  = {8'h01, 3'b100};
    t_op[2]  = OP_SUB; t_x[2]  = 8'h10; t_a[2]  = 8'h10; t_c[2]  = 1'b0; t_exp[2]  = {8'h00, 3'b010};
    t_op[3]  = OP_CMP; t_x[3]  = 8'h05; t_a[3]  = 8'h06; t_c[3]  = 1'b0; t_exp[3]  = {8'h05, 3'b101};
    t_op[4]  = OP_SHL; t_x[4]  = 8'h81; t_a[4]  = 8'h00; t_c[4]  = 1'b0; t_exp[4]  = {8'h02, 3'b100};
    t_op[5]  = OP_ROR; t_x[5]  = 8'h81; t_a[5]  = 8'h00; t_c[5]  = 1'b1; t_exp[5]  = {8'hC0, 3'b101};
    t_op[6]  = OP_INC; t_x[6]  = 8'hFF; t_a[6]  = 8'h12; t_c[6]  = 1'b0; t_exp[6]  = {8'h00, 3'b110};
    t_op[7]  = OP_DEC; t_x[7]  = 8'h00; t_a[7]  = 8'h12; t_c[7]  = 1'b0; t_exp[7]  = {8'hFF, 3'b101};
    t_op[8]  = OP_SBC; t_x[8]  = 8'h00; t_a[8]  = 8'h00; t_c[8]  = 1'b1; t_exp[8]  = {8'hFF, 3'b101};
    t_op[9]  = OP_NOT; t_x[9]  = 8'h0F; t_a[9]  = 8'h00; t_c[9]  = 1'b0; t_exp[9]  = {8'hF0, 3'b001};
    t_op[10] = OP_XOR; t_x[10] = 8'hAA; t_a[10] = 8'hFF; t_c[10] = 1'b0; t_exp[10] = {8'h55, 3'b000};
    t_op[11] = OP_AND; t_x[11] = 8'hF0; t_a[11] = 8'h0F; t_c[11] = 1'b0; t_exp[11] = {8'h00, 3'b010};
    t_op[12] = OP_OR;  t_x[12] = 8'h50; t_a[12] = 8'h0A; t_c[12] = 1'b0; t_exp[12] = {8'h5A, 3'b000};
    t_op[13] = OP_MOV; t_x[13] = 8'h11; t_a[13] = 8'h80; t_c[13] = 1'b0; t_exp[13] = {8'h80, 3'b001};
    t_op[14] = OP_ROL; t_x[14] = 8'h7F; t_a[14] = 8'h00; t_c[14] = 1'b1; t_exp[14] = {8'hFF, 3'b001};
    t_op[15] = OP_SHR; t_x[15] = 8'h01; t_a[15] = 8'h00; t_c[15] = 1'b0; t_exp[15] = {8'h00, 3'b110};
    for (int i = 0; i < 16; i++) begin
      drive(t_op[i], t_x[i], t_a[i], t_c[i], 1'b0);
      n_total++;
      if ({acc, co, z, neg} !== t_exp[i])
        $display("FAIL op_%03h vec%0d: got acc=%02h co=%b z=%b neg=%b want acc=%02h co/z/neg=%03b",
                 t_op[i], i, acc, co, z, neg, t_exp[i][10:3], t_exp[i][2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    drive(OP_ADD, 8'h80, 8'h80, 1'b0, 1'b0);
    n_total++;
    if ({acc, co, z, neg} !== {8'h00, 1'b1, 1'b1, 1'b0})
      $display("FAIL b2b_add: got acc=%02h co=%b z=%b neg=%b want 00 1 1 0", acc, co, z, neg);
    else n_pass++;
    drive(OP_SUB, 8'h03, 8'h01, 1'b0, 1'b0);
    n_total++;
    if ({acc, co, z, neg} !== {8'h02, 1'b0, 1'b0, 1'b0})
      $display("FAIL b2b_sub: got acc=%02h co=%b z=%b neg=%b want 02 0 0 0", acc, co, z, neg);
    else n_pass++;
    // Reset on the cycle after an op discards that op's result.
    drive(OP_MOV, 8'h00, 8'h9C, 1'b0, 1'b0);
    drive(OP_MOV, 8'h00, 8'h9C, 1'b0, 1'b1);
    n_total++;
    if ({acc, co, z, neg} !== {8'h00, 1'b0, 1'b1, 1'b0})
      $display("FAIL b2b_reset: got acc=%02h co=%b z=%b neg=%b want 00 0 1 0", acc, co, z, neg);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [7:0] x;
    logic       undef;
    for (int i = 0; i < 512; i++) begin
      x = 8'($urandom_range(0, 255));
      drive(9'(i), x, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
`ifdef ACC_ALU_MUL_EN
      undef = (i > 16);
`else
      undef = (i >= 16);
`endif
      if (undef) begin
        n_total++;
        if ({acc, co, z, neg} !== {x, 1'b0, (x == 8'h00), x[7]})
          $display("FAIL sweep_nop_%03h: got acc=%02h co=%b z=%b neg=%b want acc=%02h co=0 z=%b neg=%b",
                   i, acc, co, z, neg, x, (x == 8'h00), x[7]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_mul();
    drive(c_OP_MUL, 8'h10, 8'h11, 1'b0, 1'b0);
    n_total++;
`ifdef ACC_ALU_MUL_EN
    if ({acc, co, z, neg} !== {8'h10, 1'b1, 1'b0, 1'b0})
      $display("FAIL mul_en: got acc=%02h co=%b z=%b neg=%b want 10 1 0 0", acc, co, z, neg);
    else n_pass++;
`else
    if ({acc, co, z, neg} !== {8'h10, 1'b0, 1'b0, 1'b0})
      $display("FAIL mul_off: got acc=%02h co=%b z=%b neg=%b want 10 0 0 0", acc, co, z, neg);
    else n_pass++;
`endif
  endtask

  initial begin
    reset = 1'b1; op = '0; in_acc = '0; in_a = '0; ci = 1'b0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_sweep();
    test_mul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
